// File: rtl/horner_pkg.sv
// horner_pkg: shared types and constants for the Horner polynomial evaluator.
//   - default float field widths and the packed coefficient width
//   - zero-exponent encoding (most-negative exponent, zero fraction)
//   - FSM state encoding
//   - coef_at(): pull entry k out of a default-width packed coefficient bank
package horner_pkg;

    localparam int P_FRAC_WIDTH = 36;
    localparam int P_EXP_WIDTH  = 8;
    localparam int P_MAX_DEG    = 6;
    localparam int P_FLAG_W     = 3;
    localparam int P_FW         = P_FRAC_WIDTH + 4;
    localparam int COEF_W       = 1 + P_EXP_WIDTH + P_FW;
    localparam int BANK_W       = (P_MAX_DEG + 1) * COEF_W;

    localparam logic [P_EXP_WIDTH-1:0] ZERO_EXP = {1'b1, {(P_EXP_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ADD  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic [COEF_W-1:0] coef_at(input logic [BANK_W-1:0] bank, input int k);
        return bank[k*COEF_W +: COEF_W];
    endfunction

endpackage

// File: rtl/fadd_n40.sv
// fadd_n40: combinational float add on {sign, signed exp, frac} operands, same
// normalised format as fmul. Smaller operand is aligned by right shift (truncating),
// result renormalised by carry-out or leading-zero shift. Exact cancellation gives zero.
// Ports: i_sign_a/i_exp_a/i_frac_a, i_sign_b/i_exp_b/i_frac_b operands;
//        o_sign/o_exp/o_frac sum.
module fadd_n40
    import horner_pkg::*;
#(
    parameter int FRAC_W = 40,
    parameter int EXP_W  = 8
) (
    input  logic             i_sign_a,
    input  logic [EXP_W-1:0] i_exp_a,
    input  logic [FRAC_W-1:0] i_frac_a,
    input  logic             i_sign_b,
    input  logic [EXP_W-1:0] i_exp_b,
    input  logic [FRAC_W-1:0] i_frac_b,
    output logic             o_sign,
    output logic [EXP_W-1:0] o_exp,
    output logic [FRAC_W-1:0] o_frac
);
    localparam logic [EXP_W-1:0] ZEXP = {1'b1, {(EXP_W-1){1'b0}}};

    logic a_zero;
    logic b_zero;
    logic a_big;
    logic sign_l;
    logic sign_s;
    logic signed [EXP_W:0] exp_l;
    logic signed [EXP_W:0] exp_s;
    logic [FRAC_W-1:0] frac_l;
    logic [FRAC_W-1:0] frac_s;
    logic [EXP_W:0] shamt;
    logic [FRAC_W:0] sum;
    int lz;

    always_comb begin
        a_zero = (i_exp_a == ZEXP) && (i_frac_a == '0);
        b_zero = (i_exp_b == ZEXP) && (i_frac_b == '0);
        a_big  = ($signed(i_exp_a) > $signed(i_exp_b)) ||
                 ((i_exp_a == i_exp_b) && (i_frac_a >= i_frac_b));
        if (a_big) begin
            sign_l = i_sign_a; exp_l = {i_exp_a[EXP_W-1], i_exp_a}; frac_l = i_frac_a;
            sign_s = i_sign_b; exp_s = {i_exp_b[EXP_W-1], i_exp_b}; frac_s = i_frac_b;
        end else begin
            sign_l = i_sign_b; exp_l = {i_exp_b[EXP_W-1], i_exp_b}; frac_l = i_frac_b;
            sign_s = i_sign_a; exp_s = {i_exp_a[EXP_W-1], i_exp_a}; frac_s = i_frac_a;
        end
        shamt = exp_l - exp_s;
        if (sign_l == sign_s)
            sum = {1'b0, frac_l} + {1'b0, frac_s >> shamt};
        else
            sum = {1'b0, frac_l} - {1'b0, frac_s >> shamt};

        // highest set bit wins, so lz ends as the leading-zero count of sum[FRAC_W-1:0]
        lz = 0;
        for (int i = 0; i < FRAC_W; i++) begin
            if (sum[i]) lz = FRAC_W - 1 - i;
        end

        o_sign = sign_l;
        o_exp  = ZEXP;
        o_frac = '0;
        if (a_zero) begin
            o_sign = i_sign_b; o_exp = i_exp_b; o_frac = i_frac_b;
        end else if (b_zero) begin
            o_sign = i_sign_a; o_exp = i_exp_a; o_frac = i_frac_a;
        end else if (sum[FRAC_W]) begin
            o_frac = sum[FRAC_W:1];
            o_exp  = EXP_W'(exp_l + 1);
        end else if (sum == '0) begin
            o_sign = 1'b0;
        end else begin
            o_frac = FRAC_W'(sum[FRAC_W-1:0] << lz);
            o_exp  = EXP_W'(exp_l - lz);
        end
    end

endmodule

// File: rtl/fmul.sv
// fmul: combinational float multiply on {sign, signed exp, frac} operands.
// frac is normalised with its MSB as the integer bit (value = frac/2^(FRAC_W-1) * 2^exp).
// Result fraction is truncated. Zero (most-negative exp, frac 0) is handled natively.
// Ports: i_sign_a/i_exp_a/i_frac_a, i_sign_b/i_exp_b/i_frac_b operands;
//        o_sign/o_exp/o_frac product.
module fmul
    import horner_pkg::*;
#(
    parameter int FRAC_W = 40,
    parameter int EXP_W  = 8
) (
    input  logic             i_sign_a,
    input  logic [EXP_W-1:0] i_exp_a,
    input  logic [FRAC_W-1:0] i_frac_a,
    input  logic             i_sign_b,
    input  logic [EXP_W-1:0] i_exp_b,
    input  logic [FRAC_W-1:0] i_frac_b,
    output logic             o_sign,
    output logic [EXP_W-1:0] o_exp,
    output logic [FRAC_W-1:0] o_frac
);
    localparam logic [EXP_W-1:0] ZEXP = {1'b1, {(EXP_W-1){1'b0}}};

    logic [2*FRAC_W-1:0] prod;
    logic signed [EXP_W:0] exp_a;
    logic signed [EXP_W:0] exp_b;
    logic a_zero;
    logic b_zero;

    always_comb begin
        prod   = {{FRAC_W{1'b0}}, i_frac_a} * {{FRAC_W{1'b0}}, i_frac_b};
        exp_a  = {i_exp_a[EXP_W-1], i_exp_a};
        exp_b  = {i_exp_b[EXP_W-1], i_exp_b};
        a_zero = (i_exp_a == ZEXP) && (i_frac_a == '0);
        b_zero = (i_exp_b == ZEXP) && (i_frac_b == '0);
        o_sign = i_sign_a ^ i_sign_b;
        o_exp  = ZEXP;
        o_frac = '0;
        if (a_zero || b_zero) begin
            o_sign = 1'b0;
        end else if (prod[2*FRAC_W-1]) begin
            // mantissa product landed in [2,4): renormalise by one
            o_frac = FRAC_W'(prod >> FRAC_W);
            o_exp  = EXP_W'(exp_a + exp_b + 1);
        end else begin
            o_frac = FRAC_W'(prod >> (FRAC_W-1));
            o_exp  = EXP_W'(exp_a + exp_b);
        end
    end

endmodule

// File: rtl/horner_coef_bank.sv
// horner_coef_bank: registered store of MAX_DEG+1 packed coefficients.
// Ports: i_clk, i_rstn (sync, active-low); i_load captures i_coef into the bank;
//        i_sel picks an entry straight from i_coef (seed value in the accept cycle);
//        i_idx picks an entry from the stored bank (per-iteration addend).
//        Out-of-range selects read as zero.
module horner_coef_bank
    import horner_pkg::*;
#(
    parameter int MAX_DEG = 6,
    parameter int CW      = 49,
    parameter int DEG_W   = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic                      i_load,
    input  logic [(MAX_DEG+1)*CW-1:0] i_coef,
    input  logic [DEG_W-1:0]          i_sel,
    input  logic [DEG_W-1:0]          i_idx,
    output logic [CW-1:0]             o_coef_sel,
    output logic [CW-1:0]             o_coef_idx
);
    logic [CW-1:0] bank_q [MAX_DEG+1];
    logic [CW-1:0] bank_d [MAX_DEG+1];

    always_comb begin
        bank_d     = bank_q;
        o_coef_sel = '0;
        o_coef_idx = '0;
        for (int k = 0; k <= MAX_DEG; k++) begin
            if (i_load) bank_d[k] = i_coef[k*CW +: CW];
            if (i_sel == DEG_W'(k)) o_coef_sel = i_coef[k*CW +: CW];
            if (i_idx == DEG_W'(k)) o_coef_idx = bank_q[k];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            for (int k = 0; k <= MAX_DEG; k++) bank_q[k] <= '0;
        end else begin
            bank_q <= bank_d;
        end
    end

endmodule

// File: rtl/horner_eval_n.sv
// horner_eval_n: Horner-scheme polynomial evaluator p(X) = c0 + X*(c1 + X*(c2 + ...)),
// degree selectable per request up to MAX_DEG, one shared fmul and fadd_n40.
// Optional macro HORNER_ZERO_SHORTCUT_EN: a zero X skips the iterations (result c0, 1 cycle).
// Ports:
//   i_clk, i_rstn (sync, active-low)
//   request : i_valid / o_ready, i_degree, i_coef (c0 in LSBs), i_sign_x/i_exp_x/i_frac_x, i_flags
//   result  : o_valid / i_ready, o_sign_c/o_exp_c/o_frac_c, o_flags
//   o_busy  : not idle
//
// state | meaning
// IDLE  | ready; accept latches coefs, X, flags; acc = c[deg], idx = deg-1
// MUL   | prod = acc * X
// ADD   | acc = c[idx] + prod; finish when idx == 0
// DONE  | result valid, held until i_ready
module horner_eval_n #(
    parameter int FRAC_WIDTH = horner_pkg::P_FRAC_WIDTH,
    parameter int EXP_WIDTH  = horner_pkg::P_EXP_WIDTH,
    parameter int MAX_DEG    = horner_pkg::P_MAX_DEG,
    parameter int DEG_W      = $clog2(MAX_DEG + 1),
    parameter int FLAG_W     = horner_pkg::P_FLAG_W
) (
    input  logic                                            i_clk,
    input  logic                                            i_rstn,
    input  logic                                            i_valid,
    output logic                                            o_ready,
    input  logic [DEG_W-1:0]                                i_degree,
    input  logic [(MAX_DEG+1)*(1+EXP_WIDTH+FRAC_WIDTH+4)-1:0] i_coef,
    input  logic                                            i_sign_x,
    input  logic [EXP_WIDTH-1:0]                            i_exp_x,
    input  logic [FRAC_WIDTH+3:0]                           i_frac_x,
    input  logic [FLAG_W-1:0]                               i_flags,
    output logic                                            o_valid,
    input  logic                                            i_ready,
    output logic                                            o_sign_c,
    output logic [EXP_WIDTH-1:0]                            o_exp_c,
    output logic [FRAC_WIDTH+3:0]                           o_frac_c,
    output logic [FLAG_W-1:0]                               o_flags,
    output logic                                            o_busy
);
    import horner_pkg::*;

    localparam int FW = FRAC_WIDTH + 4;
    localparam int CW = 1 + EXP_WIDTH + FW;

    state_e            state_q, state_d;
    logic [DEG_W-1:0]  idx_q, idx_d;
    logic [CW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     prod_q, prod_d;
    logic [CW-1:0]     x_q, x_d;
    logic [FLAG_W-1:0] flags_q, flags_d;

    logic [DEG_W-1:0]  deg_c;
    logic [DEG_W-1:0]  sel;
    logic              load;
    logic              x_in_zero;
    logic [CW-1:0]     coef_sel;
    logic [CW-1:0]     coef_idx;
    logic [CW-1:0]     mul_out;
    logic [CW-1:0]     add_out;

`ifdef HORNER_ZERO_SHORTCUT_EN
    localparam logic [EXP_WIDTH-1:0] ZEXP = {1'b1, {(EXP_WIDTH-1){1'b0}}};
    assign x_in_zero = (i_exp_x == ZEXP) && (i_frac_x == '0);
`else
    assign x_in_zero = 1'b0;
`endif

    assign deg_c = (i_degree > DEG_W'(MAX_DEG)) ? DEG_W'(MAX_DEG) : i_degree;
    // a zero seed index means the result is c0 straight away (degree 0 or zero-X shortcut)
    assign sel   = x_in_zero ? '0 : deg_c;

    horner_coef_bank #(
        .MAX_DEG (MAX_DEG),
        .CW      (CW),
        .DEG_W   (DEG_W)
    ) u_bank (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_load     (load),
        .i_coef     (i_coef),
        .i_sel      (sel),
        .i_idx      (idx_q),
        .o_coef_sel (coef_sel),
        .o_coef_idx (coef_idx)
    );

    fmul #(
        .FRAC_W (FW),
        .EXP_W  (EXP_WIDTH)
    ) u_fmul (
        .i_sign_a (acc_q[CW-1]),
        .i_exp_a  (acc_q[CW-2 -: EXP_WIDTH]),
        .i_frac_a (acc_q[FW-1:0]),
        .i_sign_b (x_q[CW-1]),
        .i_exp_b  (x_q[CW-2 -: EXP_WIDTH]),
        .i_frac_b (x_q[FW-1:0]),
        .o_sign   (mul_out[CW-1]),
        .o_exp    (mul_out[CW-2 -: EXP_WIDTH]),
        .o_frac   (mul_out[FW-1:0])
    );

    fadd_n40 #(
        .FRAC_W (FW),
        .EXP_W  (EXP_WIDTH)
    ) u_fadd (
        .i_sign_a (coef_idx[CW-1]),
        .i_exp_a  (coef_idx[CW-2 -: EXP_WIDTH]),
        .i_frac_a (coef_idx[FW-1:0]),
        .i_sign_b (prod_q[CW-1]),
        .i_exp_b  (prod_q[CW-2 -: EXP_WIDTH]),
        .i_frac_b (prod_q[FW-1:0]),
        .o_sign   (add_out[CW-1]),
        .o_exp    (add_out[CW-2 -: EXP_WIDTH]),
        .o_frac   (add_out[FW-1:0])
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        x_d     = x_q;
        flags_d = flags_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    load    = 1'b1;
                    x_d     = {i_sign_x, i_exp_x, i_frac_x};
                    flags_d = i_flags;
                    acc_d   = coef_sel;
                    idx_d   = DEG_W'(deg_c - 1'b1);
                    state_d = (sel == '0) ? ST_DONE : ST_MUL;
                end
            end
            ST_MUL: begin
                prod_d  = mul_out;
                state_d = ST_ADD;
            end
            ST_ADD: begin
                acc_d = add_out;
                if (idx_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = DEG_W'(idx_q - 1'b1);
                    state_d = ST_MUL;
                end
            end
            ST_DONE: begin
                if (i_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            x_q     <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            x_q     <= x_d;
            flags_q <= flags_d;
        end
    end

    assign o_ready  = (state_q == ST_IDLE);
    assign o_busy   = (state_q != ST_IDLE);
    assign o_valid  = (state_q == ST_DONE);
    assign o_sign_c = acc_q[CW-1];
    assign o_exp_c  = acc_q[CW-2 -: EXP_WIDTH];
    assign o_frac_c = acc_q[FW-1:0];
    assign o_flags  = flags_q;

endmodule

// File: tb/tb_horner_eval_n.sv
module tb_horner_eval_n;

    localparam logic [48:0] ONE   = {1'b0, 8'h00, 40'h8000000000};
    localparam logic [48:0] TWO   = {1'b0, 8'h01, 40'h8000000000};
    localparam logic [48:0] THREE = {1'b0, 8'h01, 40'hC000000000};
    localparam logic [48:0] SEVEN = {1'b0, 8'h02, 40'hE000000000};
    localparam logic [48:0] R17   = {1'b0, 8'h04, 40'h8800000000};
    localparam logic [48:0] Q75   = {1'b0, 8'hFF, 40'hC000000000};
    localparam logic [48:0] MHALF = {1'b1, 8'hFF, 40'h8000000000};
    localparam logic [48:0] ZERO  = {1'b0, 8'h80, 40'h0000000000};

    logic         clk = 1'b0;
    logic         i_rstn;
    logic         i_valid;
    logic         o_ready;
    logic [2:0]   i_degree;
    logic [342:0] i_coef;
    logic         i_sign_x;
    logic [7:0]   i_exp_x;
    logic [39:0]  i_frac_x;
    logic [2:0]   i_flags;
    logic         o_valid;
    logic         i_ready;
    logic         o_sign_c;
    logic [7:0]   o_exp_c;
    logic [39:0]  o_frac_c;
    logic [2:0]   o_flags;
    logic         o_busy;

    int errors = 0;
    int checks = 0;
    logic [48:0] c [7];

    horner_eval_n dut (
        .i_clk    (clk),
        .i_rstn   (i_rstn),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_degree (i_degree),
        .i_coef   (i_coef),
        .i_sign_x (i_sign_x),
        .i_exp_x  (i_exp_x),
        .i_frac_x (i_frac_x),
        .i_flags  (i_flags),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_sign_c (o_sign_c),
        .o_exp_c  (o_exp_c),
        .o_frac_c (o_frac_c),
        .o_flags  (o_flags),
        .o_busy   (o_busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic load_coefs();
        for (int k = 0; k < 7; k++) i_coef[k*49 +: 49] = c[k];
    endtask

    // Present one request, scramble inputs after the accept edge, count edges to o_valid
    // (accept edge included) while holding i_ready low, then check result and flags.
    task automatic run_req(input string tag, input logic [2:0] deg, input logic [48:0] x,
                           input logic [2:0] fl, input int exp_lat, input logic [48:0] exp_res);
        int n;
        n = 0;
        load_coefs();
        i_degree = deg;
        {i_sign_x, i_exp_x, i_frac_x} = x;
        i_flags = fl;
        i_ready = 1'b0;
        i_valid = 1'b1;
        check({tag, " ready_before"}, 64'(o_ready), 64'd1);
        do begin
            step();
            n++;
            i_valid  = 1'b0;
            i_flags  = ~fl;
            i_degree = 3'($urandom);
            {i_sign_x, i_exp_x, i_frac_x} = {1'($urandom), 8'($urandom), 8'($urandom), 32'($urandom)};
            for (int k = 0; k < 7; k++) i_coef[k*49 +: 49] = {17'($urandom), 32'($urandom)};
        end while (!o_valid && n < 60);
        check({tag, " latency"}, 64'(n), 64'(exp_lat));
        check({tag, " result"}, 64'({o_sign_c, o_exp_c, o_frac_c}), 64'(exp_res));
        check({tag, " flags"}, 64'(o_flags), 64'(fl));
    endtask

    task automatic release_result(input string tag);
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        check({tag, " valid_after_release"}, 64'(o_valid), 64'd0);
        check({tag, " ready_after_release"}, 64'(o_ready), 64'd1);
    endtask

    initial begin
        int zlat;
        i_rstn = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_degree = '0; i_coef = '0;
        i_sign_x = 1'b0; i_exp_x = '0; i_frac_x = '0; i_flags = '0;
        repeat (3) step();
        check("reset valid", 64'(o_valid), 64'd0);
        check("reset busy", 64'(o_busy), 64'd0);
        check("reset ready", 64'(o_ready), 64'd1);
        check("reset result", 64'({o_sign_c, o_exp_c, o_frac_c}), 64'd0);
        check("reset flags", 64'(o_flags), 64'd0);
        i_rstn = 1'b1;
        step();

        // basic: 1 + 2X + 3X^2 at X=2 -> 17
        c[0] = ONE; c[1] = TWO; c[2] = THREE; c[3] = ZERO; c[4] = ZERO; c[5] = ZERO; c[6] = ZERO;
        run_req("basic", 3'd2, TWO, 3'b101, 5, R17);
        check("basic busy", 64'(o_busy), 64'd1);
        release_result("basic");

        // degree zero: c0 only
        c[0] = MHALF; c[1] = TWO; c[2] = THREE;
        run_req("deg0", 3'd0, THREE, 3'b011, 1, MHALF);
        release_result("deg0");

        // degree clamp 7 -> 6, all ones at X=1 -> 7
        for (int k = 0; k < 7; k++) c[k] = ONE;
        run_req("clamp", 3'd7, ONE, 3'b110, 13, SEVEN);
        release_result("clamp");

        // backpressure: hold DONE four cycles with a competing request present
        c[0] = ONE; c[1] = TWO; c[2] = THREE;
        for (int k = 3; k < 7; k++) c[k] = ZERO;
        run_req("bp", 3'd2, TWO, 3'b001, 5, R17);
        for (int k = 0; k < 7; k++) i_coef[k*49 +: 49] = ONE;
        i_degree = 3'd0; {i_sign_x, i_exp_x, i_frac_x} = ONE; i_flags = 3'b111;
        i_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp valid held", 64'(o_valid), 64'd1);
            check("bp ready low", 64'(o_ready), 64'd0);
            check("bp result held", 64'({o_sign_c, o_exp_c, o_frac_c}), 64'(R17));
            check("bp flags held", 64'(o_flags), 64'd1);
        end
        i_valid = 1'b0;
        release_result("bp");
        check("bp second ignored busy", 64'(o_busy), 64'd0);
        c[0] = MHALF;
        run_req("bp next", 3'd0, THREE, 3'b100, 1, MHALF);
        release_result("bp next");

        // reset during MUL of a degree-3 request
        c[0] = ONE; c[1] = TWO; c[2] = THREE; c[3] = ONE;
        load_coefs();
        i_degree = 3'd3; {i_sign_x, i_exp_x, i_frac_x} = TWO; i_flags = 3'b111;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        check("rst busy in mul", 64'(o_busy), 64'd1);
        i_rstn = 1'b0;
        step();
        i_rstn = 1'b1;
        check("rst mid valid", 64'(o_valid), 64'd0);
        check("rst mid ready", 64'(o_ready), 64'd1);
        check("rst mid result", 64'({o_sign_c, o_exp_c, o_frac_c}), 64'd0);
        check("rst mid flags", 64'(o_flags), 64'd0);
        // 1 + 3X at X=2 -> 7
        c[0] = ONE; c[1] = THREE;
        run_req("post rst", 3'd1, TWO, 3'b010, 3, SEVEN);
        release_result("post rst");

        // zero X, degree 4 -> c0
`ifdef HORNER_ZERO_SHORTCUT_EN
        zlat = 1;
`else
        zlat = 9;
`endif
        c[0] = Q75; c[1] = ONE; c[2] = TWO; c[3] = THREE; c[4] = ONE;
        run_req("zero x", 3'd4, ZERO, 3'b101, zlat, Q75);
        release_result("zero x");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
